// File: rtl/div_arbiter_if.sv
// Handshake bundle between the divider arbiter, its two requesters, the
// response consumer and the sequential divider.
interface div_arbiter_if;
    // requester 0
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_dividend;
    logic [15:0] req0_divisor;
    // requester 1
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_dividend;
    logic [15:0] req1_divisor;
    // tagged response
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_q;
    logic [15:0] rsp_r;
    logic        rsp_dz;
    logic        rsp_to;
    // divider side
    logic        div_load;
    logic [15:0] div_dividend;
    logic [15:0] div_divisor;
    logic        div_done;
    logic [15:0] div_q;
    logic [15:0] div_r;

    // arbiter side
    modport slave (
        input  req0_valid, req0_dividend, req0_divisor,
        input  req1_valid, req1_dividend, req1_divisor,
        input  rsp_ready, div_done, div_q, div_r,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_to,
        output div_load, div_dividend, div_divisor
    );

    // requesters, consumer and divider side
    modport master (
        output req0_valid, req0_dividend, req0_divisor,
        output req1_valid, req1_dividend, req1_divisor,
        output rsp_ready, div_done, div_q, div_r,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_to,
        input  div_load, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_arbiter.sv
// Two-port round-robin arbiter and sequencer for the 16-bit sequential
// divider. One operation in flight; divide-by-zero answered locally;
// watchdog aborts a divider that never reports done.
module div_arbiter #(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CW      = 6
) (
    input  logic          clk,
    input  logic          reset,
    div_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          last_q,  last_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          id_q,    id_d;
    logic [15:0]   opa_q,   opa_d;
    logic [15:0]   opb_q,   opb_d;
    logic [15:0]   rq_q,    rq_d;
    logic [15:0]   rr_q,    rr_d;
    logic          dz_q,    dz_d;
    logic          to_q,    to_d;

    logic          gnt0;
    logic          gnt1;
    logic [15:0]   sel_a;
    logic [15:0]   sel_b;

    // Grant selection: only in IDLE and out of reset; ties go to the
    // requester that was not served last.
    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        sel_a = bus.req0_dividend;
        sel_b = bus.req0_divisor;
        if (state_q == S_IDLE && reset) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
        if (gnt1) begin
            sel_a = bus.req1_dividend;
            sel_b = bus.req1_divisor;
        end
    end

    // Next-state and datapath capture for the sequencing FSM.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rq_d    = rq_q;
        rr_d    = rr_q;
        dz_d    = dz_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE: begin
                if (gnt0 || gnt1) begin
                    id_d  = gnt1;
                    opa_d = sel_a;
                    opb_d = sel_b;
                    if (sel_b == '0) begin
                        rq_d    = '1;
                        rr_d    = sel_a;
                        dz_d    = 1'b1;
                        to_d    = 1'b0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (bus.div_done) begin
                    rq_d    = bus.div_q;
                    rr_d    = bus.div_r;
                    dz_d    = 1'b0;
                    to_d    = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    rq_d    = '0;
                    rr_d    = '0;
                    dz_d    = 1'b0;
                    to_d    = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    last_d  = id_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            rq_q    <= '0;
            rr_q    <= '0;
            dz_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rq_q    <= rq_d;
            rr_q    <= rr_d;
            dz_q    <= dz_d;
            to_q    <= to_d;
        end
    end

    assign bus.req0_ready   = gnt0;
    assign bus.req1_ready   = gnt1;
    assign bus.rsp_valid    = (state_q == S_RESP);
    assign bus.rsp_id       = id_q;
    assign bus.rsp_q        = rq_q;
    assign bus.rsp_r        = rr_q;
    assign bus.rsp_dz       = dz_q;
    assign bus.rsp_to       = to_q;
    assign bus.div_load     = (state_q == S_ISSUE);
    assign bus.div_dividend = opa_q;
    assign bus.div_divisor  = opb_q;

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Sequencing controller and two-port arbiter for the team's 16-bit sequential divider. Two requesters submit dividend/divisor pairs over valid/ready handshakes; the block grants one at a time round-robin, loads the divider, and waits for completion with a watchdog. It returns a tagged quotient/remainder response. Divide-by-zero is resolved locally without occupying the divider.

## Interface
- TIMEOUT, 40: max WAIT cycles before abort; must be ≥ 2 and < 2^CW
- CW, 6: watchdog counter width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_dividend, req0_divisor  in  16  requester 0 operands
- req1_valid, req1_ready, req1_dividend, req1_divisor  same as requester 0, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index of response
- rsp_q, rsp_r  out  16  quotient, remainder
- rsp_dz  out  1  divide-by-zero flag
- rsp_to  out  1  watchdog timeout flag
- div_load  out  1  one-cycle start pulse to divider
- div_dividend, div_divisor  out  16  divider operands
- div_done  in  1  divider result valid (sampled only in WAIT)
- div_q, div_r  in  16  divider result

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Encoding is free; the state register must be visible to the bench.
- Fairness: `last` register. After reset, `last` = 1, so requester 0 wins the first tie.
- IDLE:
  - If only one valid is high, grant that requester.
  - If both are high, grant the requester ≠ `last`.
  - req*_ready is combinational and high only for the granted requester, only in IDLE.
  - On grant: capture both operands and the id.
  - Divisor == 0: load rsp_q=16'hFFFF, rsp_r=dividend, rsp_dz=1, rsp_to=0; go to RESP.
  - Otherwise go to ISSUE.
- ISSUE:
  - div_load=1 for exactly this one cycle.
  - Clear the watchdog counter.
  - Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - div_done=1: capture div_q/div_r into rsp_q/rsp_r, dz=0, to=0; go to RESP.
  - Otherwise, when the counter reaches TIMEOUT-1: rsp_q=0, rsp_r=0, rsp_to=1; go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid=1.
  - rsp_id/q/r/dz/to are held stable until a handshake (rsp_valid & rsp_ready).
  - On handshake: `last` ← rsp_id; go to IDLE.
- div_dividend/div_divisor are driven from the captured registers and stay stable from ISSUE through WAIT.
- div_done outside WAIT is ignored.
- Only one operation is in flight; no new request is accepted until the response handshake completes.

## Timing
- Reset (asynchronous assert, synchronous deassert assumed upstream):
  - state=IDLE, `last`=1, counter=0.
  - rsp_valid=0, rsp_id=0, rsp_q=0, rsp_r=0, rsp_dz=0, rsp_to=0.
  - div_load=0, div_dividend=0, div_divisor=0.
  - req*_ready=0 while reset is low.
- Reset mid-operation aborts everything. The divider is re-armed by the next div_load and no stale div_done is honoured.
- Nonzero-divisor latency:
  - Accept at edge T; div_load high during cycle T+1.
  - WAIT begins at T+2.
  - If div_done is seen in cycle T+2+k, rsp_valid rises at T+3+k.
- Zero-divisor latency: accept at T, rsp_valid high from T+1.
- Back-to-back: after the response handshake at edge H, IDLE occupies cycle H+1. Minimum one idle cycle between responses; accept can occur in that cycle.
- Timeout: rsp_valid rises TIMEOUT+1 cycles after ISSUE if done never arrives.

## Test plan
- Single request: req0 100/7, divider model done 17 cycles after load returning 14/2 -> one div_load pulse; rsp_valid with id=0, q=14, r=2, dz=0, to=0.
- Contention: req0 and req1 both valid continuously after reset -> grants alternate 0,1,0,1; each req*_ready is a single-cycle pulse; responses arrive in grant order.
- Divide by zero: req1 500/0 -> no div_load; rsp_valid one cycle after accept with id=1, q=FFFF, r=500 (0x01F4), dz=1.
- Backpressure: rsp_ready held low 10 cycles -> rsp fields stable, req*_ready stays 0, no second div_load; handshake then releases to IDLE.
- Timeout: div_done never asserted, TIMEOUT=40 -> rsp_to=1, q=0, r=0. A late div_done after the abort is ignored.
- Reset mid-WAIT: drop reset during WAIT, then re-release -> all outputs at reset values. The next request wins for requester 0 on a tie and completes normally.
